// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared line-state types, defaults and line classifier for the USB RX decoder
package usb_rx_pkg;

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_t;
    typedef enum logic {LINE, SE0} eop_state_t;

    localparam int USB_STUFF_LEN   = 6;
    localparam int USB_EOP_SE0_MIN = 2;

    // J/K depend on bus speed: J is whichever differential state has D+ at the idle level.
    function automatic line_state_t classify_line(input logic dp, input logic dm, input logic idle_dp);
        if (dp && dm) begin
            return LS_SE1;
        end
        if (!dp && !dm) begin
            return LS_SE0;
        end
        return (dp == idle_dp) ? LS_J : LS_K;
    endfunction

endpackage

// File: rtl/usb_bit_unstuffer.sv
// rtl/usb_bit_unstuffer.sv - counts consecutive decoded ones, drops stuffed zeros, flags stuff violations
module usb_bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw_bit,
    input  logic bit_strobe,
    input  logic restart,
    output logic bit_valid,
    output logic stuff_err
);

    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STUFF_LEN);

    logic [CW-1:0] ones_cnt_q;
    logic [CW-1:0] ones_cnt_d;
    logic          at_limit;

    assign at_limit  = (ones_cnt_q == LIMIT);
    assign bit_valid = bit_strobe && !at_limit;
    assign stuff_err = bit_strobe && at_limit && raw_bit;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (restart) begin
            ones_cnt_d = '0;
        end else if (bit_strobe) begin
            // The bit after a full run is consumed (dropped or flagged) either way.
            ones_cnt_d = (at_limit || !raw_bit) ? '0 : ones_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_nrzi_decoder.sv
// rtl/usb_rx_nrzi_decoder.sv - strobe-gated NRZI decode, unstuff and EOP qualify; USB_RX_SE1_DET_EN enables se1_err
module usb_rx_nrzi_decoder
    import usb_rx_pkg::*;
#(
    parameter int   STUFF_LEN   = USB_STUFF_LEN,
    parameter int   EOP_SE0_MIN = USB_EOP_SE0_MIN,
    parameter logic IDLE_DP     = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic shift_enable,
    input  logic clear,
    output logic d_orig,
    output logic d_valid,
    output logic se0_active,
    output logic eop_detected,
    output logic stuff_err,
    output logic se1_err
);

    localparam logic [2:0] SE0_MIN = 3'(EOP_SE0_MIN);

    eop_state_t  state_q, state_d;
    logic        prev_dp_q, prev_dp_d;
    logic [2:0]  se0_cnt_q, se0_cnt_d;
    logic        d_orig_q, d_orig_d;
    logic        d_valid_q, d_valid_d;
    logic        se0_active_q, se0_active_d;
    logic        eop_q, eop_d;
    logic        stuff_err_q, stuff_err_d;

    line_state_t line;
    logic        is_diff;
    logic        se0_long;
    logic        raw_bit;
    logic        bit_strobe;
    logic        restart;
    logic        bit_valid;
    logic        unstuff_err;

    assign line     = classify_line(d_plus_sync, d_minus_sync, IDLE_DP);
    assign is_diff  = (line == LS_J) || (line == LS_K);
    assign se0_long = (state_q == SE0) && (se0_cnt_q >= SE0_MIN);
    assign raw_bit  = (d_plus_sync == prev_dp_q);
    // A J/K after a short SE0 is a glitch and decodes as an ordinary bit.
    assign bit_strobe = shift_enable && !clear && is_diff && !se0_long;
    assign restart    = clear || (shift_enable && is_diff && se0_long);

    usb_bit_unstuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuffer (
        .clk        (clk),
        .n_rst      (n_rst),
        .raw_bit    (raw_bit),
        .bit_strobe (bit_strobe),
        .restart    (restart),
        .bit_valid  (bit_valid),
        .stuff_err  (unstuff_err)
    );

    always_comb begin
        state_d      = state_q;
        prev_dp_d    = prev_dp_q;
        se0_cnt_d    = se0_cnt_q;
        d_orig_d     = d_orig_q;
        d_valid_d    = 1'b0;
        se0_active_d = se0_active_q;
        eop_d        = 1'b0;
        stuff_err_d  = 1'b0;
        if (clear) begin
            state_d      = LINE;
            prev_dp_d    = IDLE_DP;
            se0_cnt_d    = 3'd0;
            d_orig_d     = 1'b1;
            se0_active_d = 1'b0;
        end else if (shift_enable) begin
            case (line)
                LS_SE0: begin
                    state_d      = SE0;
                    se0_active_d = 1'b1;
                    if (state_q == LINE) begin
                        se0_cnt_d = 3'd1;
                    end else if (se0_cnt_q != 3'd7) begin
                        se0_cnt_d = se0_cnt_q + 3'd1;
                    end
                end
                LS_SE1: begin
                    se0_active_d = 1'b0;
                end
                default: begin
                    state_d      = LINE;
                    se0_cnt_d    = 3'd0;
                    se0_active_d = 1'b0;
                    if (se0_long) begin
                        if (line == LS_J) begin
                            eop_d     = 1'b1;
                            prev_dp_d = IDLE_DP;
                        end else begin
                            prev_dp_d = d_plus_sync;
                        end
                    end else begin
                        prev_dp_d   = d_plus_sync;
                        d_valid_d   = bit_valid;
                        stuff_err_d = unstuff_err;
                        if (bit_valid) begin
                            d_orig_d = raw_bit;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= LINE;
            prev_dp_q    <= IDLE_DP;
            se0_cnt_q    <= 3'd0;
            d_orig_q     <= 1'b1;
            d_valid_q    <= 1'b0;
            se0_active_q <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_dp_q    <= prev_dp_d;
            se0_cnt_q    <= se0_cnt_d;
            d_orig_q     <= d_orig_d;
            d_valid_q    <= d_valid_d;
            se0_active_q <= se0_active_d;
            eop_q        <= eop_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

`ifdef USB_RX_SE1_DET_EN
    logic se1_err_q, se1_err_d;

    assign se1_err_d = shift_enable && !clear && (line == LS_SE1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            se1_err_q <= 1'b0;
        end else begin
            se1_err_q <= se1_err_d;
        end
    end

    assign se1_err = se1_err_q;
`else
    assign se1_err = 1'b0;
`endif

    assign d_orig       = d_orig_q;
    assign d_valid      = d_valid_q;
    assign se0_active   = se0_active_q;
    assign eop_detected = eop_q;
    assign stuff_err    = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_nrzi_decoder.sv
// tb/tb_usb_rx_nrzi_decoder.sv - directed self-checking bench for usb_rx_nrzi_decoder
module tb_usb_rx_nrzi_decoder;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus_sync;
    logic d_minus_sync;
    logic shift_enable;
    logic clear;
    logic d_orig;
    logic d_valid;
    logic se0_active;
    logic eop_detected;
    logic stuff_err;
    logic se1_err;

    int total = 0;
    int bad   = 0;

`ifdef USB_RX_SE1_DET_EN
    localparam logic SE1_EXP = 1'b1;
`else
    localparam logic SE1_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    usb_rx_nrzi_decoder dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .shift_enable (shift_enable),
        .clear        (clear),
        .d_orig       (d_orig),
        .d_valid      (d_valid),
        .se0_active   (se0_active),
        .eop_detected (eop_detected),
        .stuff_err    (stuff_err),
        .se1_err      (se1_err)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // One strobe cycle; outputs are sampled 1 ns after the capturing edge.
    task automatic strobe(input logic dp, input logic dm, input logic clr);
        @(negedge clk);
        d_plus_sync  = dp;
        d_minus_sync = dm;
        shift_enable = 1'b1;
        clear        = clr;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic sj();   strobe(1'b1, 1'b0, 1'b0); endtask
    task automatic sk();   strobe(1'b0, 1'b1, 1'b0); endtask
    task automatic se0();  strobe(1'b0, 1'b0, 1'b0); endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_bit(input string tag, input logic exp_bit);
        chk({tag, ".d_valid"}, d_valid, 1'b1);
        chk({tag, ".d_orig"}, d_orig, exp_bit);
        chk({tag, ".stuff_err"}, stuff_err, 1'b0);
    endtask

    initial begin
        logic [5:0] exp_seq;
        n_rst        = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        shift_enable = 1'b0;
        clear        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.d_orig", d_orig, 1'b1);
        chk("rst.d_valid", d_valid, 1'b0);
        chk("rst.se0_active", se0_active, 1'b0);
        chk("rst.eop", eop_detected, 1'b0);
        chk("rst.stuff_err", stuff_err, 1'b0);
        chk("rst.se1_err", se1_err, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;

        // J,K,K,J,J,J from idle J decodes to 1,0,1,0,1,1
        exp_seq = 6'b110101;
        sj(); chk_bit("seq0", exp_seq[0]);
        sk(); chk_bit("seq1", exp_seq[1]);
        sk(); chk_bit("seq2", exp_seq[2]);
        sj(); chk_bit("seq3", exp_seq[3]);
        sj(); chk_bit("seq4", exp_seq[4]);
        sj(); chk_bit("seq5", exp_seq[5]);
        idle();
        chk("seq.idle_valid", d_valid, 1'b0);
        chk("seq.idle_hold", d_orig, 1'b1);

        // Seven Js: six valid ones, seventh is a stuff violation
        do_clear();
        for (int i = 0; i < 6; i++) begin
            sj(); chk_bit($sformatf("run1_%0d", i), 1'b1);
        end
        sj();
        chk("run7.stuff_err", stuff_err, 1'b1);
        chk("run7.d_valid", d_valid, 1'b0);
        idle();
        chk("run7.pulse_end", stuff_err, 1'b0);

        // Six Js then K: stuffed zero dropped, decoding resumes
        do_clear();
        for (int i = 0; i < 6; i++) begin
            sj();
        end
        sk();
        chk("stuff0.d_valid", d_valid, 1'b0);
        chk("stuff0.stuff_err", stuff_err, 1'b0);
        sj(); chk_bit("after_stuff0", 1'b0);
        sj(); chk_bit("after_stuff1", 1'b1);

        // SE0,SE0,J is a qualified EOP
        do_clear();
        sj();
        se0();
        chk("eop.se0a_active", se0_active, 1'b1);
        chk("eop.se0a_valid", d_valid, 1'b0);
        se0();
        chk("eop.se0b_active", se0_active, 1'b1);
        chk("eop.se0b_eop", eop_detected, 1'b0);
        sj();
        chk("eop.eop", eop_detected, 1'b1);
        chk("eop.se0_off", se0_active, 1'b0);
        chk("eop.no_valid", d_valid, 1'b0);
        idle();
        chk("eop.pulse_end", eop_detected, 1'b0);
        sj(); chk_bit("post_eop", 1'b1);

        // Single SE0 glitch then J: no EOP, J decodes against the pre-glitch J
        do_clear();
        sj();
        se0();
        chk("glitch.se0_active", se0_active, 1'b1);
        sj();
        chk("glitch.eop", eop_detected, 1'b0);
        chk("glitch.se0_off", se0_active, 1'b0);
        chk_bit("glitch", 1'b1);

        // Long SE0 then K: no EOP, no bit; following J decodes against K
        do_clear();
        se0();
        se0();
        se0();
        sk();
        chk("se0k.eop", eop_detected, 1'b0);
        chk("se0k.valid", d_valid, 1'b0);
        sj(); chk_bit("se0k_next", 1'b0);

        // clear with a strobe at ones_cnt=4 wins and resets the run counter
        do_clear();
        for (int i = 0; i < 4; i++) begin
            sj();
        end
        strobe(1'b0, 1'b1, 1'b1);
        chk("clr.d_orig", d_orig, 1'b1);
        chk("clr.d_valid", d_valid, 1'b0);
        chk("clr.stuff_err", stuff_err, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sj(); chk_bit($sformatf("clr_run%0d", i), 1'b1);
        end

        // SE1 between K bits is ignored
        do_clear();
        sk(); chk_bit("se1_pre", 1'b0);
        strobe(1'b1, 1'b1, 1'b0);
        chk("se1.d_valid", d_valid, 1'b0);
        chk("se1.se1_err", se1_err, SE1_EXP);
        chk("se1.hold", d_orig, 1'b0);
        sk(); chk_bit("se1_post", 1'b1);
        chk("se1.pulse_end", se1_err, 1'b0);

        // Asynchronous reset mid-packet
        do_clear();
        sk();
        chk("arst.pre", d_orig, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("arst.d_orig", d_orig, 1'b1);
        chk("arst.d_valid", d_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        sj(); chk_bit("arst_post", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
